// File: rtl/BoomLSUST.sv
// Shared LSU/dcache types: the dcache request payload and the default request-queue depth.
package BoomLSUST;

    localparam int DCACHE_REQ_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [4:0]  cmd;
        logic [1:0]  size;
        logic [39:0] addr;
        logic [63:0] data;
        logic        is_hella;
    } BoomDCacheReqST;

    localparam int DCACHE_REQ_W = $bits(BoomDCacheReqST);

endpackage

// File: rtl/dcache_req_queue.sv
// In-order request buffer ahead of the data cache. Merges LSU and hellacache requests (LSU first)
// and lets a kill retire queued LSU entries in place, leaving them to drain silently from the head.
module dcache_req_queue
    import BoomLSUST::*;
#(
    parameter int DEPTH = DCACHE_REQ_QUEUE_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic [DCACHE_REQ_W-1:0]   lsu_req,
    input  logic                      hella_req_valid,
    output logic                      hella_req_ready,
    input  logic [DCACHE_REQ_W-1:0]   hella_req,
    input  logic                      kill,
    output logic                      dc_req_valid,
    input  logic                      dc_req_ready,
    output logic [DCACHE_REQ_W-1:0]   dc_req,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    BoomDCacheReqST   r_slot [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    BoomDCacheReqST   w_lsu_req;
    BoomDCacheReqST   w_hella_req;
    BoomDCacheReqST   w_enq_req;
    logic             w_full;
    logic             w_lsu_enq;
    logic             w_hella_enq;
    logic             w_enq;
    logic             w_enq_vld;
    logic             w_nonempty;
    logic             w_head_vld;
    logic             w_hs;
    logic             w_pop;

    assign w_lsu_req   = lsu_req;
    assign w_hella_req = hella_req;

    // Full is taken from registered state only, so a pop never frees a slot in the same cycle.
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_nonempty  = (r_count != '0);

    assign lsu_req_ready   = ~w_full;
    assign hella_req_ready = ~w_full & ~lsu_req_valid;

    assign w_lsu_enq   = lsu_req_valid & ~w_full;
    assign w_hella_enq = hella_req_valid & ~w_full & ~lsu_req_valid;
    assign w_enq       = w_lsu_enq | w_hella_enq;
    assign w_enq_vld   = w_lsu_enq ? ~kill : 1'b1;

    always_comb begin
        w_enq_req = w_hella_req;
        w_enq_req.is_hella = 1'b1;
        if (w_lsu_enq) begin
            w_enq_req = w_lsu_req;
            w_enq_req.is_hella = 1'b0;
        end
    end

    assign w_head_vld   = w_nonempty & r_valid[r_head];
    assign dc_req_valid = w_head_vld;
    assign dc_req       = r_slot[r_head];
    assign count        = r_count;

    // Dead head entries leave without a dcache handshake, one per cycle.
    assign w_hs  = w_head_vld & dc_req_ready;
    assign w_pop = w_nonempty & (w_hs | ~r_valid[r_head]);

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_slot[r_tail] <= w_enq_req;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // A head entry handshaken this cycle is already delivered, so kill must not touch it.
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!r_slot[i].is_hella && !(w_hs && (IDX_W'(i) == r_head))) begin
                        r_valid[i] <= 1'b0;
                    end
                end
            end
            if (w_enq) begin
                r_valid[r_tail] <= w_enq_vld;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_req_queue.sv
// Bench for dcache_req_queue: a queue-of-entries model checked every cycle plus directed scenarios.
module tb_dcache_req_queue;
    import BoomLSUST::*;

    localparam int DEPTH = 4;
    localparam int W     = DCACHE_REQ_W;

    logic          clock;
    logic          reset_n;
    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic [W-1:0]  lsu_req;
    logic          hella_req_valid;
    logic          hella_req_ready;
    logic [W-1:0]  hella_req;
    logic          kill;
    logic          dc_req_valid;
    logic          dc_req_ready;
    logic [W-1:0]  dc_req;
    logic [2:0]    count;

    dcache_req_queue #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .lsu_req_valid   (lsu_req_valid),
        .lsu_req_ready   (lsu_req_ready),
        .lsu_req         (lsu_req),
        .hella_req_valid (hella_req_valid),
        .hella_req_ready (hella_req_ready),
        .hella_req       (hella_req),
        .kill            (kill),
        .dc_req_valid    (dc_req_valid),
        .dc_req_ready    (dc_req_ready),
        .dc_req          (dc_req),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        BoomDCacheReqST p;
        bit             alive;
    } mentry_t;

    mentry_t        q[$];
    BoomDCacheReqST delivered[$];
    bit             model_on;
    int             tests;
    int             fails;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mkreq(input logic [39:0] a);
        BoomDCacheReqST t;
        t.cmd      = 5'($urandom);
        t.size     = 2'($urandom);
        t.addr     = a;
        t.data     = {$urandom, $urandom};
        t.is_hella = 1'($urandom);
        return t;
    endfunction

    function automatic logic [39:0] addr_of(input logic [W-1:0] v);
        BoomDCacheReqST t;
        t = v;
        return t.addr;
    endfunction

    function automatic logic hella_of(input logic [W-1:0] v);
        BoomDCacheReqST t;
        t = v;
        return t.is_hella;
    endfunction

    // Model: compare outputs mid-cycle, then advance the queue to its post-edge contents.
    always @(negedge clock) begin
        if (model_on) begin
            bit      full;
            bit      dcv;
            bit      hs;
            mentry_t e;
            full = (q.size() == DEPTH);
            dcv  = (q.size() != 0) && q[0].alive;
            check("count", count, q.size());
            check("lsu_ready", lsu_req_ready, !full);
            check("hella_ready", hella_req_ready, !full && !lsu_req_valid);
            check("dc_valid", dc_req_valid, dcv);
            if (dcv) check("dc_req", dc_req, q[0].p);
            if (dc_req_valid && dc_req_ready) delivered.push_back(dc_req);
            hs = dcv && dc_req_ready;
            if (q.size() != 0 && (hs || !q[0].alive)) void'(q.pop_front());
            if (kill) begin
                foreach (q[i]) if (!q[i].p.is_hella) q[i].alive = 1'b0;
            end
            if (!full && lsu_req_valid) begin
                e.p = lsu_req;
                e.p.is_hella = 1'b0;
                e.alive = !kill;
                q.push_back(e);
            end else if (!full && hella_req_valid) begin
                e.p = hella_req;
                e.p.is_hella = 1'b1;
                e.alive = 1'b1;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_lsu(input logic [39:0] a);
        lsu_req_valid = 1'b1;
        lsu_req = mkreq(a);
        tick();
        lsu_req_valid = 1'b0;
    endtask

    initial begin
        int d0;
        tests = 0;
        fails = 0;
        model_on = 1'b0;
        reset_n = 1'b0;
        lsu_req_valid = 1'b0;
        hella_req_valid = 1'b0;
        lsu_req = '0;
        hella_req = '0;
        kill = 1'b0;
        dc_req_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_on = 1'b1;
        #1;
        check("rst_count", count, 0);
        check("rst_dcv", dc_req_valid, 0);
        check("rst_lrdy", lsu_req_ready, 1);
        check("rst_hrdy", hella_req_ready, 1);

        // Single LSU request visible next cycle
        push_lsu(40'h1000);
        #1;
        check("t1_dcv", dc_req_valid, 1);
        check("t1_addr", addr_of(dc_req), 40'h1000);
        check("t1_hella", hella_of(dc_req), 0);
        check("t1_count", count, 1);
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        #1;
        check("t1_drain", count, 0);

        // LSU wins over hella
        lsu_req_valid = 1'b1;
        lsu_req = mkreq(40'h2000);
        hella_req_valid = 1'b1;
        hella_req = mkreq(40'h2100);
        #1;
        check("t2_lrdy", lsu_req_ready, 1);
        check("t2_hrdy", hella_req_ready, 0);
        tick();
        lsu_req_valid = 1'b0;
        #1;
        check("t2_hrdy2", hella_req_ready, 1);
        tick();
        hella_req_valid = 1'b0;
        #1;
        check("t2_count", count, 2);
        check("t2_head", addr_of(dc_req), 40'h2000);
        check("t2_head_h", hella_of(dc_req), 0);
        dc_req_ready = 1'b1;
        tick();
        #1;
        check("t2_second", addr_of(dc_req), 40'h2100);
        check("t2_second_h", hella_of(dc_req), 1);
        tick();
        dc_req_ready = 1'b0;
        #1;
        check("t2_drain", count, 0);

        // Fill to full, then drain in order
        for (int i = 0; i < 4; i++) push_lsu(40'h3000 + 40'(i));
        #1;
        check("t3_count", count, 4);
        check("t3_lrdy", lsu_req_ready, 0);
        d0 = delivered.size();
        dc_req_ready = 1'b1;
        repeat (4) tick();
        dc_req_ready = 1'b0;
        #1;
        check("t3_drain", count, 0);
        check("t3_ndel", delivered.size(), d0 + 4);
        for (int i = 0; i < 4; i++)
            if (d0 + i < delivered.size())
                check("t3_order", delivered[d0+i].addr, 40'h3000 + 40'(i));

        // Kill leaves only the hella entry deliverable
        push_lsu(40'h4000);
        hella_req_valid = 1'b1;
        hella_req = mkreq(40'h4100);
        tick();
        hella_req_valid = 1'b0;
        push_lsu(40'h4200);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        #1;
        check("t4_count3", count, 3);
        check("t4_dcv", dc_req_valid, 0);
        d0 = delivered.size();
        dc_req_ready = 1'b1;
        tick();
        #1;
        check("t4_count2", count, 2);
        check("t4_head", addr_of(dc_req), 40'h4100);
        tick();
        #1;
        check("t4_count1", count, 1);
        tick();
        dc_req_ready = 1'b0;
        #1;
        check("t4_count0", count, 0);
        check("t4_ndel", delivered.size(), d0 + 1);
        if (delivered.size() > d0) check("t4_del", delivered[d0].addr, 40'h4100);

        // Kill coinciding with head handshake
        push_lsu(40'h5000);
        push_lsu(40'h5100);
        d0 = delivered.size();
        kill = 1'b1;
        dc_req_ready = 1'b1;
        tick();
        kill = 1'b0;
        dc_req_ready = 1'b0;
        #1;
        check("t5_count1", count, 1);
        check("t5_dcv", dc_req_valid, 0);
        tick();
        #1;
        check("t5_count0", count, 0);
        check("t5_ndel", delivered.size(), d0 + 1);
        if (delivered.size() > d0) check("t5_del", delivered[d0].addr, 40'h5000);

        // Full queue: pop and new request in the same cycle, enqueue waits
        for (int i = 0; i < 4; i++) push_lsu(40'h6000 + 40'(i));
        d0 = delivered.size();
        lsu_req_valid = 1'b1;
        lsu_req = mkreq(40'h6FF0);
        dc_req_ready = 1'b1;
        #1;
        check("t6_lrdy_full", lsu_req_ready, 0);
        tick();
        dc_req_ready = 1'b0;
        #1;
        check("t6_count3", count, 3);
        check("t6_lrdy", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        #1;
        check("t6_count4", count, 4);
        dc_req_ready = 1'b1;
        repeat (4) tick();
        dc_req_ready = 1'b0;
        #1;
        check("t6_ndel", delivered.size(), d0 + 5);
        if (delivered.size() == d0 + 5) begin
            check("t6_d0", delivered[d0].addr, 40'h6000);
            check("t6_d4", delivered[d0+4].addr, 40'h6FF0);
        end

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            lsu_req_valid   = ($urandom_range(0, 99) < 40);
            hella_req_valid = ($urandom_range(0, 99) < 30);
            kill            = ($urandom_range(0, 99) < 8);
            dc_req_ready    = ($urandom_range(0, 99) < 55);
            lsu_req         = mkreq({8'h0, $urandom});
            hella_req       = mkreq({8'h1, $urandom});
            tick();
        end
        lsu_req_valid = 1'b0;
        hella_req_valid = 1'b0;
        kill = 1'b0;
        dc_req_ready = 1'b0;

        // Asynchronous reset with entries pending
        for (int i = 0; i < 3; i++) push_lsu(40'h7000 + 40'(i));
        reset_n = 1'b0;
        model_on = 1'b0;
        #1;
        check("rst2_count", count, 0);
        check("rst2_dcv", dc_req_valid, 0);
        check("rst2_lrdy", lsu_req_ready, 1);
        check("rst2_hrdy", hella_req_ready, 1);
        tick();
        q.delete();
        reset_n = 1'b1;
        model_on = 1'b1;
        tick();
        #1;
        check("rst2_after", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
